me_batch_ctrl: RTL

//  Board-level sequencer between push buttons and the full-search ME core. Debounces start/abort/select

---
 rtl/me_batch_ctrl_if.sv | 15 +
 rtl/me_batch_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/me_batch_ctrl_if.sv
// Request/acknowledge bundle between the batch sequencer and the full-search ME core.
interface me_batch_ctrl_if #(
  parameter int SAD_W = 16,
  parameter int MV_W  = 12,
  parameter int IDX_W = 2
);
  logic             me_req;
  logic             me_ack;
  logic [SAD_W-1:0] me_min_sad;
  logic [MV_W-1:0]  me_min_mvec;
  logic [IDX_W-1:0] tb_idx;

  modport master (output me_req, tb_idx, input me_ack, me_min_sad, me_min_mvec);
  modport slave  (input me_req, tb_idx, output me_ack, me_min_sad, me_min_mvec);
endinterface

// File: rtl/me_batch_ctrl.sv
// Push-button batch sequencer for the ME core: debounce, 4-phase req/ack over NUM_TB blocks,
// result file and best-block tracking. Optional cycle counter under ME_PERF_CNT_EN.

// One button: 2-FF sync, level changes after DEB_CYCLES equal samples, pulse on release->press.
module me_deb #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic RSTN,
  input  logic raw,
  output logic press
);
  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]    sync;
  logic          lvl;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      sync  <= 2'b11;
      lvl   <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES-1)) begin
        cnt   <= '0;
        lvl   <= sync[1];
        press <= lvl;  // only the 1->0 transition yields a pulse
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module me_batch_ctrl #(
  parameter  int TB_LENGTH    = 16,
  parameter  int SW_LENGTH    = 64,
  parameter  int PE_OUT_WIDTH = 8,
  parameter  int NUM_TB       = 4,
  parameter  int DEB_CYCLES   = 16,
  localparam int SAD_W = $clog2(TB_LENGTH**2) + PE_OUT_WIDTH,
  localparam int MV_W  = $clog2((SW_LENGTH-TB_LENGTH+1)**2),
  localparam int IDX_W = (NUM_TB > 1) ? $clog2(NUM_TB) : 1,
  localparam int TBA_W = $clog2(TB_LENGTH**2)
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic             btn_start_n,
  input  logic             btn_abort_n,
  input  logic             btn_sel_n,
  me_batch_ctrl_if.master  core,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] sel_idx,
  output logic [SAD_W-1:0] sel_sad,
  output logic [MV_W-1:0]  sel_mvec,
  output logic [IDX_W-1:0] best_idx,
  output logic [SAD_W-1:0] best_sad
`ifdef ME_PERF_CNT_EN
  ,output logic [31:0]     perf_cycles
  ,output logic            perf_valid
`endif
);
  localparam int NUM_BTN = 3;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_REL   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TB-1);

  // button order: 0 start, 1 abort, 2 select
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_press;
  assign btn_raw = {btn_sel_n, btn_abort_n, btn_start_n};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_deb
    me_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .RSTN  (RSTN),
      .raw   (btn_raw[gi]),
      .press (btn_press[gi])
    );
  end

  logic start_p, abort_p, sel_p;
  assign start_p = btn_press[0];
  assign abort_p = btn_press[1];
  assign sel_p   = btn_press[2];

  logic [1:0]                   state;
  logic [NUM_TB-1:0][SAD_W-1:0] res_sad;
  logic [NUM_TB-1:0][MV_W-1:0]  res_mvec;

  logic start_go, abort_go, fin_go, last;
  assign last     = (core.tb_idx == LAST_IDX);
  assign start_go = (state == ST_IDLE) && start_p && !abort_p;
  assign abort_go = ((state == ST_REQ) || (state == ST_REL)) && abort_p;
  assign fin_go   = (state == ST_REL) && !abort_p && !core.me_ack && last;

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state       <= ST_IDLE;
      core.me_req <= 1'b0;
      core.tb_idx <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      best_idx    <= '0;
      best_sad    <= '1;
      res_sad     <= '0;
      res_mvec    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_go) begin
            state       <= ST_REQ;
            core.me_req <= 1'b1;
            core.tb_idx <= '0;
            busy        <= 1'b1;
            done        <= 1'b0;
            best_idx    <= '0;
            best_sad    <= '1;
          end
        end
        ST_REQ: begin
          if (abort_go) begin
            core.me_req <= 1'b0;
            state       <= ST_DRAIN;
          end else if (core.me_ack) begin
            res_sad[core.tb_idx]  <= core.me_min_sad;
            res_mvec[core.tb_idx] <= core.me_min_mvec;
            // strict compare: a tie keeps the earlier block
            if (core.me_min_sad < best_sad) begin
              best_sad <= core.me_min_sad;
              best_idx <= core.tb_idx;
            end
            core.me_req <= 1'b0;
            state       <= ST_REL;
          end
        end
        ST_REL: begin
          if (abort_go) begin
            state <= ST_DRAIN;
          end else if (fin_go) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (!core.me_ack) begin
            core.tb_idx <= core.tb_idx + 1'b1;
            core.me_req <= 1'b1;
            state       <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (!core.me_ack) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // display path: index stepping and registered readout of the result file
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      sel_idx  <= '0;
      sel_sad  <= '0;
      sel_mvec <= '0;
    end else begin
      if (sel_p) sel_idx <= (sel_idx == LAST_IDX) ? '0 : sel_idx + 1'b1;
      sel_sad  <= res_sad[sel_idx];
      sel_mvec <= res_mvec[sel_idx];
    end
  end

`ifdef ME_PERF_CNT_EN
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      perf_cycles <= '0;
      perf_valid  <= 1'b0;
    end else begin
      if (start_go)
        perf_cycles <= '0;
      else if (core.me_req && (perf_cycles != '1))
        perf_cycles <= perf_cycles + 1'b1;
      if (start_go || abort_go) perf_valid <= 1'b0;
      else if (fin_go)          perf_valid <= 1'b1;
    end
  end
`endif

endmodule
